// File: rtl/mvm_host_8_20_if.sv
// Host-side bundle for mvm_host_8_20: input stream, result stream and MVM control/data lines.
interface mvm_host_8_20_if #(
    parameter int B = 20
);
    logic           in_valid;
    logic           in_ready;
    logic [B-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*B-1:0] out_data;
    logic           mvm_loadMatrix;
    logic           mvm_loadVector;
    logic           mvm_start;
    logic [B-1:0]   mvm_data_in;
    logic           mvm_done;
    logic [2*B-1:0] mvm_data_out;
    logic           err;

    modport slave (
        input  in_valid, in_data, out_ready, mvm_done, mvm_data_out,
        output in_ready, out_valid, out_data, mvm_loadMatrix, mvm_loadVector,
               mvm_start, mvm_data_in, err
    );

    modport master (
        output in_valid, in_data, out_ready, mvm_done, mvm_data_out,
        input  in_ready, out_valid, out_data, mvm_loadMatrix, mvm_loadVector,
               mvm_start, mvm_data_in, err
    );
endinterface

// File: rtl/mvm_host_8_20.sv
// Host sequencer for a KxK matrix-vector unit: buffers a job, replays it to the MVM, queues results.
// Optional MVM_HOST_WDOG_EN adds an 8-bit WAIT watchdog that aborts the job and pulses err.
module mvm_host_8_20 #(
    parameter int K = 8,
    parameter int B = 20
) (
    input  logic           clk,
    input  logic           reset,
    mvm_host_8_20_if.slave bus
);
    localparam int NW = K*K + K;
    localparam int AW = $clog2(NW);
    localparam int FW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(K + 1);

    typedef enum logic [3:0] {
        COLLECT, LDM, SENDM, LDV, SENDV, START, WAIT, CAPTURE, DRAIN
    } state_t;

    state_t         r_state, w_next;
    logic [B-1:0]   r_buf  [NW];
    logic [2*B-1:0] r_fifo [K];
    logic [AW-1:0]  r_waddr, r_idx;
    logic [FW-1:0]  r_wp, r_rp;
    logic [CW-1:0]  r_cnt;
    logic           r_run;
    logic           w_in_ready, w_in_hs, w_push, w_pop;
`ifdef MVM_HOST_WDOG_EN
    logic [7:0]     r_wdog;
    logic           w_err;
`endif

    // r_run keeps in_ready low until the first edge after reset releases
    assign w_in_ready = (r_state == COLLECT) && r_run;
    assign w_in_hs    = w_in_ready && bus.in_valid;
    assign w_pop      = (r_cnt != '0) && bus.out_ready;

    always_comb begin
        w_next             = r_state;
        w_push             = 1'b0;
        bus.mvm_loadMatrix = 1'b0;
        bus.mvm_loadVector = 1'b0;
        bus.mvm_start      = 1'b0;
        bus.mvm_data_in    = '0;
`ifdef MVM_HOST_WDOG_EN
        w_err              = 1'b0;
`endif
        case (r_state)
            COLLECT: if (w_in_hs && r_waddr == AW'(NW-1)) w_next = LDM;
            LDM: begin
                bus.mvm_loadMatrix = 1'b1;
                w_next             = SENDM;
            end
            SENDM: begin
                bus.mvm_data_in = r_buf[r_idx];
                if (r_idx == AW'(K*K-1)) w_next = LDV;
            end
            LDV: begin
                bus.mvm_loadVector = 1'b1;
                w_next             = SENDV;
            end
            // r_idx carries on from K*K so the vector is read straight from the tail of the buffer
            SENDV: begin
                bus.mvm_data_in = r_buf[r_idx];
                if (r_idx == AW'(NW-1)) w_next = START;
            end
            START: begin
                bus.mvm_start = 1'b1;
                w_next        = WAIT;
            end
            WAIT: begin
                if (bus.mvm_done) w_next = CAPTURE;
`ifdef MVM_HOST_WDOG_EN
                else if (r_wdog == 8'hFF) begin
                    w_err  = 1'b1;
                    w_next = COLLECT;
                end
`endif
            end
            CAPTURE: begin
                w_push = 1'b1;
                if (r_idx == AW'(K-1)) w_next = DRAIN;
            end
            DRAIN: if (r_cnt == '0 || (r_cnt == CW'(1) && w_pop)) w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
            r_run   <= 1'b0;
            r_waddr <= '0;
            r_idx   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (w_in_hs)
                r_waddr <= (r_waddr == AW'(NW-1)) ? '0 : r_waddr + AW'(1);
            case (r_state)
                SENDM, SENDV, CAPTURE: r_idx <= r_idx + AW'(1);
                COLLECT, START, DRAIN: r_idx <= '0;
                default: ;
            endcase
            if (w_push) r_wp <= (r_wp == FW'(K-1)) ? '0 : r_wp + FW'(1);
            if (w_pop)  r_rp <= (r_rp == FW'(K-1)) ? '0 : r_rp + FW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef MVM_HOST_WDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wdog <= '0;
        else       r_wdog <= (r_state == WAIT) ? r_wdog + 8'd1 : 8'd0;
    end
    assign bus.err = w_err;
`else
    assign bus.err = 1'b0;
`endif

    // Storage arrays need no reset: pointers alone define what is live
    always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[r_waddr] <= bus.in_data;
        if (w_push)  r_fifo[r_wp]   <= bus.mvm_data_out;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_cnt != '0);
    assign bus.out_data  = r_fifo[r_rp];
endmodule

// File: tb/tb_mvm_host_8_20.sv
// Randomized bench for mvm_host_8_20 with an MVM behavioural model and a result scoreboard.
module tb_mvm_host_8_20;
    localparam int K  = 8;
    localparam int B  = 20;
    localparam int RW = 2*B;
    localparam int NW = K*K + K;

    typedef struct packed {
        logic         lm;
        logic         lv;
        logic         st;
        logic [B-1:0] d;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mvm_host_8_20_if #(.B(B)) bus();
    mvm_host_8_20 #(.K(K), .B(B)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0, n_fail = 0, cyc_n = 0, strays = 0, err_cnt = 0;
    int err_cyc = -1, st_cyc = -1, rel_cyc = -1;
    int vmode = 0, rmode = 0, dn_cnt = -1, res_i = -1, lat = 0;
    bit tog = 1'b0, spur = 1'b0, suppress = 1'b0;

    logic [B-1:0]  jA [K*K];
    logic [B-1:0]  jx [K];
    logic [RW-1:0] my [K];
    logic [B-1:0]  in_q [$];
    logic [B-1:0]  rcv  [$];
    logic [RW-1:0] exp_q [$];
    ev_t           ev_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the job words and compute y = A*x with plain arithmetic, truncated to 2B bits
    task automatic load_job();
        longint acc;
        in_q.delete();
        for (int n = 0; n < K*K; n++) in_q.push_back(jA[n]);
        for (int n = 0; n < K; n++) in_q.push_back(jx[n]);
        for (int i = 0; i < K; i++) begin
            acc = 0;
            for (int j = 0; j < K; j++)
                acc += longint'($signed(jA[i*K+j])) * longint'($signed(jx[j]));
            exp_q.push_back(acc[RW-1:0]);
        end
        lat     = $urandom_range(0, 4);
        rel_cyc = -1;
        tog     = 1'b0;
    endtask

    task automatic rand_job();
        for (int n = 0; n < K*K; n++) jA[n] = B'($urandom());
        for (int n = 0; n < K; n++) jx[n] = B'($urandom());
    endtask

    task automatic cyc();
        ev_t    e;
        longint acc;
        @(negedge clk);
        cyc_n++;
        case (vmode)
            0:       bus.in_valid = (in_q.size() > 0);
            1:       bus.in_valid = (in_q.size() > 0) && tog;
            default: bus.in_valid = (in_q.size() > 0) && ($urandom_range(0, 1) == 1);
        endcase
        tog = ~tog;
        bus.in_data = (in_q.size() > 0) ? in_q[0] : '0;
        case (rmode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 1) == 1);
            default: bus.out_ready = (rel_cyc >= 0) && (cyc_n > rel_cyc);
        endcase
        bus.mvm_done     = 1'b0;
        bus.mvm_data_out = RW'({$urandom(), $urandom()});
        if (res_i >= 0) begin
            bus.mvm_data_out = my[res_i];
            if (res_i == K-1) begin
                rel_cyc = cyc_n;
                res_i   = -1;
            end else res_i++;
        end
        if (dn_cnt == 0) begin
            bus.mvm_done = 1'b1;
            res_i  = 0;
            dn_cnt = -1;
        end else if (dn_cnt > 0) dn_cnt--;
        if (spur) begin
            bus.mvm_done = 1'b1;
            spur = 1'b0;
        end
        #1;
        if (rmode == 2 && rel_cyc >= 0 && cyc_n == rel_cyc + 1)
            chk("hold_out_valid", bus.out_valid, 1);
        if (bus.in_valid && bus.in_ready) void'(in_q.pop_front());
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("out_extra", 1, 0);
            else chk("out_data", bus.out_data, exp_q.pop_front());
        end
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc_n;
        end
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk("mvm_trace", {bus.mvm_loadMatrix, bus.mvm_loadVector, bus.mvm_start, bus.mvm_data_in},
                {e.lm, e.lv, e.st, e.d});
            if (!e.lm && !e.lv && !e.st) rcv.push_back(bus.mvm_data_in);
            if (e.st) begin
                st_cyc = cyc_n;
                if (rcv.size() == NW) begin
                    for (int i = 0; i < K; i++) begin
                        acc = 0;
                        for (int j = 0; j < K; j++)
                            acc += longint'($signed(rcv[i*K+j])) * longint'($signed(rcv[K*K+j]));
                        my[i] = acc[RW-1:0];
                    end
                end
                if (!suppress) dn_cnt = lat;
            end
        end else if (bus.mvm_loadMatrix) begin
            chk("lm_cycle", {bus.mvm_loadVector, bus.mvm_start, bus.mvm_data_in}, '0);
            rcv.delete();
            for (int n = 0; n < K*K; n++) ev_q.push_back('{1'b0, 1'b0, 1'b0, jA[n]});
            ev_q.push_back('{1'b0, 1'b1, 1'b0, '0});
            for (int n = 0; n < K; n++) ev_q.push_back('{1'b0, 1'b0, 1'b0, jx[n]});
            ev_q.push_back('{1'b0, 1'b0, 1'b1, '0});
        end else if (bus.mvm_loadVector || bus.mvm_start || bus.mvm_data_in != '0) begin
            strays++;
        end
    endtask

    task automatic run_job(input string tag);
        int guard = 0;
        load_job();
        do begin
            cyc();
            guard++;
        end while ((in_q.size() > 0 || exp_q.size() > 0 || ev_q.size() > 0 || dn_cnt >= 0 || res_i >= 0)
                   && guard < 3000);
        chk({tag, "_timeout"}, (guard >= 3000), 0);
        cyc();
        chk({tag, "_idle_in_ready"}, bus.in_ready, 1);
        chk({tag, "_idle_out_valid"}, bus.out_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.mvm_done = 1'b0; bus.mvm_data_out = '0;
        in_q.delete(); exp_q.delete(); ev_q.delete(); rcv.delete();
        dn_cnt = -1; res_i = -1; spur = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_strobes", {bus.mvm_loadMatrix, bus.mvm_loadVector, bus.mvm_start}, 0);
        chk("rst_mvm_data_in", bus.mvm_data_in, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_rdy_before_edge", bus.in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_rdy_after_edge", bus.in_ready, 1);
    endtask

    initial begin
        int guard;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.mvm_done = 1'b0; bus.mvm_data_out = '0;
        do_reset();

        // identity, x = 1..K, gap-free input
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) jA[i*K+j] = (i == j) ? B'(1) : B'(0);
        for (int j = 0; j < K; j++) jx[j] = B'(j + 1);
        vmode = 0; rmode = 0;
        run_job("ident");

        // all -1 matrix, x = 2, in_valid toggling
        for (int n = 0; n < K*K; n++) jA[n] = '1;
        for (int j = 0; j < K; j++) jx[j] = B'(2);
        vmode = 1; rmode = 0;
        run_job("neg");

        // out_ready held low through capture, then released
        rand_job();
        vmode = 0; rmode = 2;
        run_job("hold");

        // reset after 30 accepted words, then a full job with a stray mvm_done in COLLECT
        rand_job();
        vmode = 0; rmode = 0;
        load_job();
        guard = 0;
        while (in_q.size() > NW - 30 && guard < 200) begin
            cyc();
            guard++;
        end
        chk("midjob_timeout", (guard >= 200), 0);
        do_reset();
        rand_job();
        vmode = 2; rmode = 1; spur = 1'b1;
        run_job("after_rst");

        for (int t = 0; t < 3; t++) begin
            rand_job();
            vmode = 2; rmode = 1;
            run_job("rand");
        end

`ifdef MVM_HOST_WDOG_EN
        rand_job();
        vmode = 0; rmode = 0; suppress = 1'b1;
        load_job();
        guard = 0;
        while (err_cnt == 0 && guard < 1000) begin
            cyc();
            guard++;
        end
        chk("wdog_timeout", (guard >= 1000), 0);
        chk("wdog_delay", err_cyc - st_cyc, 256);
        exp_q.delete();
        cyc();
        chk("wdog_in_ready", bus.in_ready, 1);
        chk("wdog_err_pulse", bus.err, 0);
        suppress = 1'b0;
        chk("err_count", err_cnt, 1);
`else
        chk("err_count", err_cnt, 0);
`endif
        chk("stray_mvm_activity", strays, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mvm_host_8_20.md
MVM_HOST_8_20 -- requirements
Module: mvm_host_8_20

Interface
REQ-001 SHALL have parameter K, default 8: matrix dimension; the matrix is KxK and the vector is K words.
REQ-002 SHALL have parameter B, default 20: signed input word width; result width is 2B.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream word on in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, B bits: stream of K*K matrix words in row-major order, then K vector words.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid result.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-010 SHALL have port out_data, output, 2B bits: result y[i], in order i=0..K-1.
REQ-011 SHALL have ports mvm_loadMatrix, mvm_loadVector and mvm_start, each output, 1 bit: single-cycle strobes to the MVM.
REQ-012 SHALL have port mvm_data_in, output, B bits: word stream to the MVM.
REQ-013 SHALL have port mvm_done, input, 1 bit: the MVM completion pulse.
REQ-014 SHALL have port mvm_data_out, input, 2B bits: the MVM result stream.
REQ-015 SHALL have port err, output, 1 bit: watchdog error pulse.

Function
REQ-016 SHALL implement states COLLECT, LDM, SENDM, LDV, SENDV, START, WAIT, CAPTURE and DRAIN.
REQ-017 In COLLECT, in_ready SHALL be 1; each in_valid&in_ready handshake SHALL write one word into a local buffer of K*K+K words, at sequential addresses.
REQ-018 When word K*K+K-1 is accepted, the next state SHALL be LDM; in every other state in_ready SHALL be 0.
REQ-019 In LDM, mvm_loadMatrix SHALL be 1 for exactly one cycle; the next state is SENDM.
REQ-020 In SENDM, mvm_data_in SHALL present A[0]..A[K*K-1] on K*K consecutive cycles, gap-free, with A[0] in the cycle after the loadMatrix strobe.
REQ-021 LDV then SENDV SHALL behave the same way: one loadVector strobe, then x[0]..x[K-1] on K consecutive cycles.
REQ-022 START SHALL assert mvm_start for one cycle, in the cycle after x[K-1]; the next state is WAIT.
REQ-023 WAIT SHALL hold until mvm_done=1; the next state is CAPTURE.
REQ-024 In CAPTURE, mvm_data_out SHALL be written into a K-entry result FIFO on the K consecutive cycles starting the cycle after mvm_done.
REQ-025 Capture SHALL never stall; out_ready has no effect on capture.
REQ-026 out_valid SHALL be 1 whenever the result FIFO is non-empty.
REQ-027 Each out_valid&out_ready handshake SHALL pop one entry; pops SHALL be allowed during CAPTURE, and a simultaneous push and pop SHALL keep the count unchanged.
REQ-028 After the K-th capture, the state SHALL be DRAIN.
REQ-029 DRAIN SHALL return to COLLECT when the FIFO becomes empty, with the write address cleared for the next job.
REQ-030 mvm_data_in SHALL be 0 outside SENDM and SENDV.
REQ-031 Strobes SHALL be 0 outside their own states.
REQ-032 An mvm_done seen outside WAIT SHALL be ignored.
REQ-033 Results SHALL pass through unmodified, with no sign or width conversion.

Reset
REQ-034 Reset SHALL force state COLLECT and clear all counters and FIFO pointers, immediately and asynchronously.
REQ-035 During reset, in_ready=0, out_valid=0, err=0, all strobes=0, and mvm_data_in=0.
REQ-036 in_ready SHALL be 1 from the first clock edge after reset deasserts.
REQ-037 Reset mid-job SHALL discard all buffered data; the block SHALL NOT reset the MVM itself.

Configuration
REQ-038 With MVM_HOST_WDOG_EN defined, an 8-bit watchdog SHALL count cycles in WAIT.
REQ-039 If that watchdog reaches 255 without mvm_done, err SHALL pulse for 1 cycle and the state SHALL go to COLLECT with all buffers cleared.
REQ-040 Without MVM_HOST_WDOG_EN, WAIT SHALL have no timeout and err SHALL be tied to 0.

Verification
REQ-041 Identity matrix with x=1..8 streamed with no gaps -> loadMatrix, 64 words, loadVector, 8 words, start; out_data sequence 1..8.
REQ-042 A[i][j]=-1 for all i,j, x[j]=2, with in_valid toggling every other cycle -> mvm_data_in is still gap-free; every result is -16.
REQ-043 out_ready held 0 during CAPTURE, then held 1 -> 8 results are retained and drained in order; the state returns to COLLECT.
REQ-044 Reset asserted after 30 input words, then a full job -> the first job is discarded; the second result is correct.
REQ-045 With MVM_HOST_WDOG_EN and mvm_done held 0 -> err pulses 255 cycles after entering WAIT, and in_ready=1 the next cycle.
